llr_section_loader: RTL and testbench

LLR_SECTION_LOADER -- requirements
Module: llr_section_loader

---
 rtl/llr_section_loader.sv | 124 ++++++++++++
 tb/tb_llr_section_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/llr_section_loader.sv
// Collects one frame of K {ba1,ba2,ba3} LLR beats, then holds them while the decoder runs ITER half-iterations.
// Optional build macro LOADER_ERR_STALL_EN: a Razor error during decoding replays the cycle without counting it.
module llr_section_loader #(
  parameter int N    = 6,
  parameter int M    = 6,
  parameter int K    = 8,
  parameter int ITER = 16,
  localparam int CW  = $clog2(ITER + 1),
  localparam int IW  = (K > 1) ? $clog2(K) : 1
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [M-1:0]  in_ba1,
  input  logic signed [N-1:0]  in_ba2,
  input  logic signed [N-1:0]  in_ba3,
  input  logic                 Error_any,
  output logic [K*M-1:0]       ba1_DFF,
  output logic [K*N-1:0]       ba2,
  output logic [K*N-1:0]       ba3,
  output logic                 Enable,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        iter_cnt
);

  typedef enum logic [1:0] {LOAD, DECODE, DONE} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_iter;
  logic [K*M-1:0]  r_ba1;
  logic [K*N-1:0]  r_ba2;
  logic [K*N-1:0]  r_ba3;
  logic            r_enable;
  logic            r_busy;
  logic            r_done;

  logic            w_accept;
  logic            w_stall;
  logic [CW-1:0]   w_iter_next;

  assign in_ready    = (r_state == LOAD);
  assign w_accept    = in_valid && in_ready;
  assign w_iter_next = r_iter + CW'(1);

`ifdef LOADER_ERR_STALL_EN
  assign w_stall = Error_any;
`else
  assign w_stall = Error_any & 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_state  <= LOAD;
      r_idx    <= '0;
      r_iter   <= '0;
      r_ba1    <= '0;
      r_ba2    <= '0;
      r_ba3    <= '0;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_done <= 1'b0;
          if (w_accept) begin
            for (int s = 0; s < K; s++) begin
              if (r_idx == IW'(s)) begin
                r_ba1[s*M +: M] <= in_ba1;
                r_ba2[s*N +: N] <= in_ba2;
                r_ba3[s*N +: N] <= in_ba3;
              end
            end
            if (r_idx == IW'(K - 1)) begin
              r_idx    <= '0;
              r_state  <= DECODE;
              r_enable <= 1'b1;
              r_busy   <= 1'b1;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        DECODE: begin
          // A stalled cycle keeps Enable high so the sections replay the same iteration.
          if (!w_stall) begin
            r_iter <= w_iter_next;
            if (w_iter_next == CW'(ITER)) begin
              r_state  <= DONE;
              r_enable <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= LOAD;
          r_done  <= 1'b0;
          r_iter  <= '0;
        end
        default: begin
          r_state  <= LOAD;
          r_idx    <= '0;
          r_iter   <= '0;
          r_enable <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign ba1_DFF  = r_ba1;
  assign ba2      = r_ba2;
  assign ba3      = r_ba3;
  assign Enable   = r_enable;
  assign busy     = r_busy;
  assign done     = r_done;
  assign iter_cnt = r_iter;

endmodule

// File: tb/tb_llr_section_loader.sv
// Randomized bench for llr_section_loader; a per-section array model and iteration counter predict every output.
module tb_llr_section_loader;
  localparam int N    = 6;
  localparam int M    = 6;
  localparam int K    = 8;
  localparam int ITER = 16;
  localparam int CW   = $clog2(ITER + 1);
`ifdef LOADER_ERR_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic                Clock = 1'b0;
  logic                nReset;
  logic                in_valid;
  logic                in_ready;
  logic signed [M-1:0] in_ba1;
  logic signed [N-1:0] in_ba2;
  logic signed [N-1:0] in_ba3;
  logic                Error_any;
  logic [K*M-1:0]      ba1_DFF;
  logic [K*N-1:0]      ba2;
  logic [K*N-1:0]      ba3;
  logic                Enable;
  logic                busy;
  logic                done;
  logic [CW-1:0]       iter_cnt;

  llr_section_loader #(.N(N), .M(M), .K(K), .ITER(ITER)) dut (
    .Clock(Clock), .nReset(nReset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ba1(in_ba1), .in_ba2(in_ba2), .in_ba3(in_ba3), .Error_any(Error_any),
    .ba1_DFF(ba1_DFF), .ba2(ba2), .ba3(ba3), .Enable(Enable), .busy(busy),
    .done(done), .iter_cnt(iter_cnt)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [M-1:0] m1 [K];
  logic [N-1:0] m2 [K];
  logic [N-1:0] m3 [K];
  int           exp_idx = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_model();
    for (int s = 0; s < K; s++) begin
      m1[s] = '0; m2[s] = '0; m3[s] = '0;
    end
    exp_idx = 0;
  endtask

  task automatic check_fields(input string tag);
    logic [K*M-1:0] e1;
    logic [K*N-1:0] e2, e3;
    for (int s = 0; s < K; s++) begin
      e1[s*M +: M] = m1[s];
      e2[s*N +: N] = m2[s];
      e3[s*N +: N] = m3[s];
    end
    check({tag, "_ba1"}, 64'(ba1_DFF), 64'(e1));
    check({tag, "_ba2"}, 64'(ba2), 64'(e2));
    check({tag, "_ba3"}, 64'(ba3), 64'(e3));
  endtask

  task automatic drive_random_data();
    in_ba1 = M'($urandom);
    in_ba2 = N'($urandom);
    in_ba3 = N'($urandom);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    Error_any = 1'b0;
    nReset    = 1'b0;
    tick();
    nReset = 1'b1;
    clear_model();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_en"},   64'(Enable),   64'(0));
    check({tag, "_busy"}, 64'(busy),     64'(0));
    check({tag, "_done"}, 64'(done),     64'(0));
    check({tag, "_iter"}, 64'(iter_cnt), 64'(0));
    check({tag, "_rdy"},  64'(in_ready), 64'(1));
    check_fields(tag);
  endtask

  // pattern: 0 back-to-back, 1 alternate valid 1,0,1,0..., 2 random gaps; seq puts idx+1 on ba1.
  task automatic load_beats(input int pattern, input bit seq, input int nbeats);
    int  got = 0;
    int  cyc = 0;
    bit  v, rdy;
    logic [M-1:0] d1;
    logic [N-1:0] d2, d3;
    while (got < nbeats && cyc < 400) begin
      case (pattern)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(99) < 60);
      endcase
      drive_random_data();
      if (seq) in_ba1 = M'(exp_idx + 1);
      d1 = in_ba1; d2 = in_ba2; d3 = in_ba3;
      in_valid = v;
      rdy = in_ready;
      tick();
      in_valid = 1'b0;
      cyc++;
      if (v && rdy) begin
        m1[exp_idx] = d1; m2[exp_idx] = d2; m3[exp_idx] = d3;
        exp_idx = (exp_idx + 1) % K;
        got++;
      end
      check_fields("load");
      if (got > 0 && exp_idx == 0 && v) begin
        check("load_en_last", 64'(Enable), 64'(1));
        check("load_rdy_last", 64'(in_ready), 64'(0));
      end else begin
        check("load_en", 64'(Enable), 64'(0));
        check("load_rdy", 64'(in_ready), 64'(1));
      end
    end
    if (got < nbeats) check("load_timeout", 64'(got), 64'(nbeats));
  endtask

  // err_mode: 0 none, 1 errors on the 3rd/7th/11th Enable cycles, 2 random. stop_at >= 0 resets there.
  task automatic run_decode(input int err_mode, input int stop_at);
    int exp_it = 0;
    int en_cnt = 0;
    int stalls = 0;
    int guard  = 0;
    bit err;
    while (!done && guard < 80) begin
      guard++;
      check("dec_en",   64'(Enable),   64'(1));
      check("dec_busy", 64'(busy),     64'(1));
      check("dec_rdy",  64'(in_ready), 64'(0));
      check("dec_iter", 64'(iter_cnt), 64'(exp_it));
      check_fields("dec");
      if (exp_it == stop_at) begin
        do_reset();
        check_idle("rst_dec");
        return;
      end
      if (Enable) en_cnt++;
      case (err_mode)
        0:       err = 1'b0;
        1:       err = (en_cnt == 3 || en_cnt == 7 || en_cnt == 11);
        default: err = ($urandom_range(99) < 20);
      endcase
      Error_any = err;
      in_valid  = $urandom_range(1);
      drive_random_data();
      tick();
      Error_any = 1'b0;
      in_valid  = 1'b0;
      if (STALL && err) stalls++;
      else exp_it++;
    end
    check("dec_done",      64'(done),     64'(1));
    check("dec_done_en",   64'(Enable),   64'(0));
    check("dec_done_busy", 64'(busy),     64'(0));
    check("dec_done_rdy",  64'(in_ready), 64'(0));
    check("dec_done_iter", 64'(iter_cnt), 64'(ITER));
    check("dec_en_cycles", 64'(en_cnt),   64'(ITER + stalls));
    if (err_mode == 1) check("dec_en_cycles3", 64'(en_cnt), STALL ? 64'(ITER + 3) : 64'(ITER));
    check_fields("done");
    in_valid = 1'b1;
    drive_random_data();
    tick();
    in_valid = 1'b0;
    check_idle("post_done");
  endtask

  initial begin
    in_valid  = 1'b0;
    in_ba1    = '0;
    in_ba2    = '0;
    in_ba3    = '0;
    Error_any = 1'b0;
    nReset    = 1'b0;
    tick();
    tick();
    nReset = 1'b1;
    clear_model();
    check_idle("reset");

    load_beats(0, 1'b1, K);
    run_decode(0, -1);

    load_beats(1, 1'b0, K);
    run_decode(1, -1);

    load_beats(2, 1'b0, K);
    run_decode(2, -1);

    load_beats(2, 1'b0, 5);
    do_reset();
    check_idle("rst_load");
    load_beats(0, 1'b0, K);
    run_decode(0, 7);

    for (int f = 0; f < 5; f++) begin
      load_beats(2, 1'b0, K);
      run_decode(2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
